// File: rtl/bitlet_plane_scheduler.sv
// bitlet_plane_scheduler: walks a tile one bit-plane at a time through a Bitlet check window and forwards its beats.
// Optional build macro BITLET_SKIP_ZERO_PLANE_EN: planes whose active lanes are all zero bypass the window.
module bitlet_plane_scheduler #(
   parameter int N_total = 64,
   parameter int N_bits  = 24,
   localparam int NW = (N_total > 1) ? $clog2(N_total) : 1,
   localparam int BW = (N_bits > 1) ? $clog2(N_bits) : 1
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic               abort,
   input  logic [NW-1:0]      N_calculate,
   output logic               busy,
   output logic               done,
   output logic               plane_req,
   output logic [BW-1:0]      plane_idx,
   input  logic               plane_vld,
   input  logic [N_total-1:0] plane_data,
   output logic               win_flush,
   output logic               win_en,
   output logic [N_total-1:0] win_Wtrans,
   output logic [NW-1:0]      win_N_calculate,
   input  logic               win_sel_vld,
   input  logic               win_zero,
   input  logic [NW-1:0]      win_sel,
   input  logic               acc_ready,
   output logic               out_vld,
   output logic [NW-1:0]      out_sel,
   output logic               out_zero,
   output logic [BW-1:0]      out_plane
);
   typedef enum logic [2:0] {IDLE, FETCH, FLUSH, ARM, RUN, NEXT, DONE} state_t;
   state_t state, state_n;
   logic abort_pend, seen, xfer, last, skip;
   assign xfer = state == FETCH && plane_vld;
   assign last = plane_idx == BW'(N_bits - 1);
`ifdef BITLET_SKIP_ZERO_PLANE_EN
   logic [N_total-1:0] mask;
   // lanes 0..N_calculate of the latched lane count
   always_comb
      for (int i = 0; i < N_total; i++) mask[i] = i <= int'(win_N_calculate);
   assign skip = ~|(plane_data & mask);
`else
   assign skip = 1'b0;
`endif
   assign busy      = state != IDLE;
   assign done      = state == DONE;
   assign plane_req = state == FETCH;
   assign win_flush = state == FLUSH;
   assign win_en    = state == ARM;
   // next-state: one plane per pass, abort forces a single flush cycle before IDLE
   always_comb begin
      state_n = state;
      unique case (state)
         IDLE:  state_n = start ? FETCH : IDLE;
         FETCH: state_n = plane_vld ? (skip ? NEXT : FLUSH) : FETCH;
         FLUSH: state_n = abort_pend ? IDLE : ARM;
         ARM:   state_n = RUN;
         RUN:   state_n = (seen && !win_sel_vld) ? NEXT : RUN;
         NEXT:  state_n = last ? DONE : (acc_ready ? FETCH : NEXT);
         DONE:  state_n = IDLE;
         default: state_n = IDLE;
      endcase
      if (abort && state != IDLE) state_n = FLUSH;
   end
   // control state, plane counter and window operand registers
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         state           <= IDLE;
         abort_pend      <= 1'b0;
         seen            <= 1'b0;
         plane_idx       <= '0;
         win_Wtrans      <= '0;
         win_N_calculate <= '0;
      end else begin
         state           <= state_n;
         abort_pend      <= abort && state != IDLE;
         seen            <= state == RUN && state_n == RUN && (seen || win_sel_vld);
         plane_idx       <= state_n == IDLE ? '0 : (state == NEXT && state_n == FETCH) ? plane_idx + 1'b1 : plane_idx;
         win_N_calculate <= (state == IDLE && start) ? N_calculate : win_N_calculate;
         win_Wtrans      <= xfer ? plane_data : win_Wtrans;
      end
   // forward window results every cycle, tagged with the current plane
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         out_vld   <= 1'b0;
         out_sel   <= '0;
         out_zero  <= 1'b0;
         out_plane <= '0;
      end else begin
         out_vld   <= win_sel_vld;
         out_sel   <= win_sel;
         out_zero  <= win_zero;
         out_plane <= plane_idx;
      end
endmodule

// File: tb/tb_bitlet_plane_scheduler.sv
// tb_bitlet_plane_scheduler: directed bench with a behavioural window and plane source.
module tb_bitlet_plane_scheduler;
   localparam int NT = 64, NB = 4;
   logic clk = 1'b0, rst = 1'b1, start = 1'b0, abort = 1'b0, acc_ready = 1'b1;
   logic [5:0] n_calc = '0;
   logic busy, done, plane_req, win_flush, win_en, out_vld, out_zero;
   logic [1:0] plane_idx, out_plane;
   logic plane_vld = 1'b0, win_sel_vld = 1'b0, win_zero = 1'b0;
   logic [63:0] plane_data = '0, win_wtrans;
   logic [5:0] win_sel = '0, win_ncalc, out_sel;
   logic [63:0] planes [NB];
   int total = 0, bad = 0, cyc = 0, vld_delay = 0, req_cnt = 0, dly = -1, done_cnt = 0, both_cnt = 0;
   int beats[$], beat_cyc[$], flush_cyc[$], en_cyc[$], xfer_cyc[$], wq[$];

   bitlet_plane_scheduler #(.N_total(NT), .N_bits(NB)) dut (
      .clk(clk), .rst(rst), .start(start), .abort(abort), .N_calculate(n_calc),
      .busy(busy), .done(done), .plane_req(plane_req), .plane_idx(plane_idx),
      .plane_vld(plane_vld), .plane_data(plane_data), .win_flush(win_flush), .win_en(win_en),
      .win_Wtrans(win_wtrans), .win_N_calculate(win_ncalc), .win_sel_vld(win_sel_vld),
      .win_zero(win_zero), .win_sel(win_sel), .acc_ready(acc_ready), .out_vld(out_vld),
      .out_sel(out_sel), .out_zero(out_zero), .out_plane(out_plane));

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   // window model: beats start two cycles after en, one per set lane, a zero beat per empty 8-lane step
   always @(negedge clk) begin
      int b;
      bit any;
      if (rst || win_flush) begin wq.delete(); dly = -1; end
      if (dly == 0 && wq.size() > 0) begin
         b = wq.pop_front();
         win_sel_vld = 1'b1; win_zero = b < 0; win_sel = b < 0 ? 6'd0 : 6'(b);
      end else begin
         win_sel_vld = 1'b0; win_zero = 1'b0; win_sel = '0;
      end
      if (dly > 0) dly--;
      if (win_en) begin
         for (int w = 0; w * 8 <= int'(win_ncalc); w++) begin
            any = 1'b0;
            for (int l = w * 8; l < w * 8 + 8 && l <= int'(win_ncalc); l++)
               if (win_wtrans[l]) begin wq.push_back(l); any = 1'b1; end
            if (!any) wq.push_back(-1);
         end
         dly = 1;
      end
   end

   // plane source: answers a request after vld_delay cycles
   always @(negedge clk) begin
      if (!rst && plane_req && req_cnt >= vld_delay) begin
         plane_vld = 1'b1; plane_data = planes[plane_idx]; xfer_cyc.push_back(cyc);
      end else plane_vld = 1'b0;
      req_cnt = plane_req ? req_cnt + 1 : 0;
   end

   // monitor
   always @(negedge clk) begin
      if (out_vld) begin beats.push_back(int'({out_plane, out_zero, out_sel})); beat_cyc.push_back(cyc); end
      if (done) done_cnt++;
      if (win_flush) flush_cyc.push_back(cyc);
      if (win_en) en_cyc.push_back(cyc);
      if (win_flush && win_en) both_cnt++;
   end

   function automatic int bt(input int p, input int z, input int s);
      return p * 128 + z * 64 + s;
   endfunction

   task automatic tick;
      @(negedge clk); #1;
   endtask

   task automatic clear_logs;
      beats.delete(); beat_cyc.delete(); flush_cyc.delete(); en_cyc.delete(); xfer_cyc.delete();
   endtask

   task automatic set_planes(input logic [63:0] v, input int d);
      for (int i = 0; i < NB; i++) planes[i] = v;
      vld_delay = d;
   endtask

   task automatic go(input logic [5:0] nc);
      n_calc = nc; start = 1'b1; tick; start = 1'b0;
   endtask

   task automatic wait_idle(input int lim);
      int n = 0;
      while (busy && n < lim) begin tick; n++; end
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL wait_idle: busy=%0b after %0d cycles, need 0", busy, lim); end
   endtask

   task automatic wait_beat;
      int n = 0;
      while (beats.size() == 0 && n < 100) begin tick; n++; end
      total++; if (beats.size() == 0) begin bad++; $display("FAIL wait_beat: beats=0, need >=1"); end
   endtask

   task automatic test_reset;
      repeat (2) tick;
      total++; if ({busy, done, plane_req, win_flush, win_en, out_vld, out_zero} !== 7'd0) begin bad++; $display("FAIL reset_flags: got %b need 0", {busy, done, plane_req, win_flush, win_en, out_vld, out_zero}); end
      total++; if (plane_idx !== 2'd0) begin bad++; $display("FAIL reset_idx: got %0d need 0", plane_idx); end
      total++; if (win_wtrans !== 64'd0) begin bad++; $display("FAIL reset_wtrans: got %h need 0", win_wtrans); end
      total++; if (win_ncalc !== 6'd0) begin bad++; $display("FAIL reset_ncalc: got %0d need 0", win_ncalc); end
      total++; if ({out_sel, out_plane} !== 8'd0) begin bad++; $display("FAIL reset_out: got %h need 0", {out_sel, out_plane}); end
      rst = 1'b0; tick;
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL idle_busy: got %0b need 0", busy); end
   endtask

   task automatic test_single;
      int d0 = done_cnt;
      set_planes(64'h3, 0); clear_logs; go(6'd15);
      total++; if (plane_req !== 1'b1) begin bad++; $display("FAIL single_req: got %0b need 1", plane_req); end
      total++; if (win_ncalc !== 6'd15) begin bad++; $display("FAIL single_ncalc: got %0d need 15", win_ncalc); end
      total++; if (plane_idx !== 2'd0) begin bad++; $display("FAIL single_idx: got %0d need 0", plane_idx); end
      wait_idle(300);
      total++; if (done_cnt !== d0 + 1) begin bad++; $display("FAIL single_done: got %0d need %0d", done_cnt - d0, 1); end
      total++; if (beats.size() !== 12) begin bad++; $display("FAIL single_count: got %0d need 12", beats.size()); end
      for (int i = 0; i < 12 && i < beats.size(); i++) begin
         total++; if (beats[i] !== bt(i / 3, i % 3 == 2, i % 3 == 2 ? 0 : i % 3)) begin bad++; $display("FAIL single_beat%0d: got %h need %h", i, beats[i], bt(i / 3, i % 3 == 2, i % 3 == 2 ? 0 : i % 3)); end
      end
   endtask

   task automatic test_handshake;
      int c0, d0 = done_cnt;
      set_planes(64'h8000, 3); clear_logs; go(6'd15); c0 = cyc;
      wait_idle(400);
      total++; if (done_cnt !== d0 + 1) begin bad++; $display("FAIL hs_done: got %0d need 1", done_cnt - d0); end
      total++; if (xfer_cyc.size() !== 4 || flush_cyc.size() !== 4 || en_cyc.size() !== 4 || beats.size() !== 8) begin bad++; $display("FAIL hs_counts: got xfer=%0d flush=%0d en=%0d beats=%0d need 4/4/4/8", xfer_cyc.size(), flush_cyc.size(), en_cyc.size(), beats.size()); end
      else begin
         total++; if (xfer_cyc[0] !== c0 + 3) begin bad++; $display("FAIL hs_delay: got %0d need %0d", xfer_cyc[0], c0 + 3); end
         for (int i = 0; i < 4; i++) begin
            total++; if (flush_cyc[i] !== xfer_cyc[i] + 1) begin bad++; $display("FAIL hs_flush%0d: got %0d need %0d", i, flush_cyc[i], xfer_cyc[i] + 1); end
            total++; if (en_cyc[i] !== xfer_cyc[i] + 2) begin bad++; $display("FAIL hs_en%0d: got %0d need %0d", i, en_cyc[i], xfer_cyc[i] + 2); end
            total++; if (beat_cyc[2 * i] !== xfer_cyc[i] + 5) begin bad++; $display("FAIL hs_out%0d: got %0d need %0d", i, beat_cyc[2 * i], xfer_cyc[i] + 5); end
            total++; if (beats[2 * i] !== bt(i, 1, 0) || beats[2 * i + 1] !== bt(i, 0, 15)) begin bad++; $display("FAIL hs_beats%0d: got %h %h need %h %h", i, beats[2 * i], beats[2 * i + 1], bt(i, 1, 0), bt(i, 0, 15)); end
         end
      end
   endtask

   task automatic test_zero_plane;
      int d0 = done_cnt;
      set_planes(64'h0, 0); clear_logs; go(6'd63);
      wait_idle(600);
      total++; if (done_cnt !== d0 + 1) begin bad++; $display("FAIL zero_done: got %0d need 1", done_cnt - d0); end
`ifdef BITLET_SKIP_ZERO_PLANE_EN
      total++; if (beats.size() !== 0 || flush_cyc.size() !== 0 || en_cyc.size() !== 0) begin bad++; $display("FAIL zero_skip: got beats=%0d flush=%0d en=%0d need 0/0/0", beats.size(), flush_cyc.size(), en_cyc.size()); end
      total++; if (xfer_cyc.size() !== 4) begin bad++; $display("FAIL zero_xfers: got %0d need 4", xfer_cyc.size()); end
      else begin
         total++; if (xfer_cyc[1] !== xfer_cyc[0] + 2) begin bad++; $display("FAIL zero_next: got %0d need %0d", xfer_cyc[1], xfer_cyc[0] + 2); end
      end
`else
      total++; if (beats.size() !== 32) begin bad++; $display("FAIL zero_count: got %0d need 32", beats.size()); end
      for (int i = 0; i < 32 && i < beats.size(); i++) begin
         total++; if (beats[i] !== bt(i / 8, 1, 0)) begin bad++; $display("FAIL zero_beat%0d: got %h need %h", i, beats[i], bt(i / 8, 1, 0)); end
      end
`endif
   endtask

   task automatic test_backpressure;
      int d0 = done_cnt;
      set_planes(64'h1, 0); clear_logs; acc_ready = 1'b0; go(6'd7);
      repeat (25) tick;
      total++; if (xfer_cyc.size() !== 1 || en_cyc.size() !== 1) begin bad++; $display("FAIL bp_hold: got xfer=%0d en=%0d need 1/1", xfer_cyc.size(), en_cyc.size()); end
      total++; if ({busy, plane_req, plane_idx} !== 4'b1000) begin bad++; $display("FAIL bp_state: got %b need 1000", {busy, plane_req, plane_idx}); end
      total++; if (beats.size() !== 1) begin bad++; $display("FAIL bp_beats: got %0d need 1", beats.size()); end
      acc_ready = 1'b1; tick;
      total++; if ({plane_req, plane_idx} !== 3'b101) begin bad++; $display("FAIL bp_resume: got %b need 101", {plane_req, plane_idx}); end
      wait_idle(300);
      total++; if (beats.size() !== 4 || done_cnt !== d0 + 1) begin bad++; $display("FAIL bp_finish: got beats=%0d done=%0d need 4/1", beats.size(), done_cnt - d0); end
   endtask

   task automatic test_abort;
      int d0 = done_cnt;
      set_planes(64'h3, 0); clear_logs; go(6'd15);
      wait_beat;
      abort = 1'b1; tick; abort = 1'b0;
      total++; if ({win_flush, win_en, busy} !== 3'b101) begin bad++; $display("FAIL abort_flush: got %b need 101", {win_flush, win_en, busy}); end
      tick;
      total++; if ({busy, win_flush, plane_req} !== 3'b000) begin bad++; $display("FAIL abort_idle: got %b need 000", {busy, win_flush, plane_req}); end
      repeat (3) tick;
      total++; if (done_cnt !== d0) begin bad++; $display("FAIL abort_nodone: got %0d need 0", done_cnt - d0); end
      clear_logs; go(6'd15);
      total++; if ({plane_req, plane_idx} !== 3'b100) begin bad++; $display("FAIL abort_restart: got %b need 100", {plane_req, plane_idx}); end
      wait_idle(300);
      total++; if (beats.size() !== 12 || done_cnt !== d0 + 1) begin bad++; $display("FAIL abort_rerun: got beats=%0d done=%0d need 12/1", beats.size(), done_cnt - d0); end
   endtask

   task automatic test_async_reset;
      int d0;
      set_planes(64'h3, 0); clear_logs; go(6'd15);
      wait_beat;
      #2 rst = 1'b1; #1;
      total++; if ({busy, done, plane_req, plane_idx, win_flush, win_en, win_wtrans, win_ncalc, out_vld, out_sel, out_zero, out_plane} !== '0) begin bad++; $display("FAIL arst_outputs: got busy=%0b vld=%0b wtrans=%h ncalc=%0d need all 0", busy, out_vld, win_wtrans, win_ncalc); end
      tick; rst = 1'b0; tick;
      d0 = done_cnt; clear_logs; go(6'd15);
      total++; if ({plane_req, plane_idx} !== 3'b100) begin bad++; $display("FAIL arst_restart: got %b need 100", {plane_req, plane_idx}); end
      wait_idle(300);
      total++; if (beats.size() !== 12 || done_cnt !== d0 + 1) begin bad++; $display("FAIL arst_rerun: got beats=%0d done=%0d need 12/1", beats.size(), done_cnt - d0); end
      total++; if (beats.size() > 0 && beats[0] !== bt(0, 0, 0)) begin bad++; $display("FAIL arst_first: got %h need %h", beats[0], bt(0, 0, 0)); end
   endtask

   initial begin
      test_reset;
      test_single;
      test_handshake;
      test_zero_plane;
      test_backpressure;
      test_abort;
      test_async_reset;
      total++; if (both_cnt !== 0) begin bad++; $display("FAIL flush_en_overlap: got %0d need 0", both_cnt); end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
